// File: rtl/data_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : data_bus_arbiter
// Purpose  : Two-master / one-slave MEM-stage data bus arbiter with bounded
//            master-1 starvation and slave timeout abort.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic                  core_stall,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_req,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_ack
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_busy_m0 = 2'd1;
    localparam logic [1:0] c_st_busy_m1 = 2'd2;
    localparam logic [3:0] c_max_wait   = 4'(MAX_WAIT);
    localparam logic [7:0] c_tmo_last   = 8'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  s_we_q, s_we_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
    logic                  m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic                  m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic w_idle, w_busy, w_done, w_abort, w_grant_m0, w_grant_m1;

    // A master is not re-granted in its own ack cycle; the raw m0_req still
    // blocks master 1 there, so M0 keeps its turn until the starve limit.
    assign w_idle     = (state_q == c_st_idle);
    assign w_busy     = ~w_idle;
    assign w_grant_m1 = w_idle & m1_req & ~m1_ack_q & ((starve_q == c_max_wait) | ~m0_req);
    assign w_grant_m0 = w_idle & ~w_grant_m1 & m0_req & ~m0_ack_q;
    assign w_done     = w_busy & s_ack;
    assign w_abort    = w_busy & ~s_ack & (tmo_q == c_tmo_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= c_st_idle;
            starve_q   <= '0;
            tmo_q      <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        tmo_d      = '0;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = (state_q == c_st_busy_m0) & (w_done | w_abort);
        m0_err_d   = (state_q == c_st_busy_m0) & w_abort;
        m1_ack_d   = (state_q == c_st_busy_m1) & (w_done | w_abort);
        m1_err_d   = (state_q == c_st_busy_m1) & w_abort;

        case (state_q)
            c_st_idle: begin
                if (w_grant_m1) begin
                    state_d   = c_st_busy_m1;
                    s_we_d    = m1_we;
                    s_addr_d  = m1_addr;
                    s_wdata_d = m1_wdata;
                end else if (w_grant_m0) begin
                    state_d   = c_st_busy_m0;
                    s_we_d    = m0_we;
                    s_addr_d  = m0_addr;
                    s_wdata_d = m0_wdata;
                end
            end
            c_st_busy_m0, c_st_busy_m1: begin
                if (w_done || w_abort) state_d = c_st_idle;
                else                   tmo_d   = tmo_q + 8'd1;
            end
            default: state_d = c_st_idle;
        endcase

        if (state_q == c_st_busy_m0 && w_done)  m0_rdata_d = s_rdata;
        if (state_q == c_st_busy_m0 && w_abort) m0_rdata_d = '0;
        if (state_q == c_st_busy_m1 && w_done)  m1_rdata_d = s_rdata;
        if (state_q == c_st_busy_m1 && w_abort) m1_rdata_d = '0;

        if (w_grant_m1)
            starve_d = '0;
        else if (w_grant_m0 && m1_req)
            starve_d = (starve_q == c_max_wait) ? starve_q : starve_q + 4'd1;
        else if (!m1_req)
            starve_d = '0;
    end

    always_comb begin
        s_req      = w_busy;
        core_stall = m0_req & ~m0_ack_q;
    end

    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_data_bus_arbiter
// Purpose  : Randomized bench for data_bus_arbiter against a transaction-level
//            reference model of the arbitration rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 4;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          mreq [0:1];
    logic          mwe  [0:1];
    logic [AW-1:0] maddr[0:1];
    logic [DW-1:0] mwd  [0:1];
    logic [DW-1:0] m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic [AW-1:0] s_addr;
    logic          m0_ack, m0_err, m1_ack, m1_err, core_stall;
    logic          s_req, s_we, s_ack;

    always #5 i_clk = ~i_clk;

    data_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .m0_req(mreq[0]), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwd[0]),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err), .core_stall(core_stall),
        .m1_req(mreq[1]), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwd[1]),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus, how long it has waited, how many
    // M0 grants M1 has sat through, and the values each master should see.
    int            own;
    int            elapsed;
    int            starve;
    bit            e_ack[0:1];
    bit            e_err[0:1];
    logic [DW-1:0] e_rd [0:1];
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    int p_req[0:1];
    bit cont;
    int ack_pct;
    int run, last_run, since_m1, m1_seen;
    bit phase_b;

    task automatic model_reset();
        own = -1; elapsed = 0; starve = 0;
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = 0; e_err[i] = 0; e_rd[i] = '0;
        end
        e_we = 0; e_addr = '0; e_wd = '0;
        run = 0; last_run = 0;
    endtask

    task automatic new_txn(input int i);
        mreq[i]  = 1'b1;
        mwe[i]   = 1'($urandom_range(0, 1));
        maddr[i] = $urandom;
        mwd[i]   = $urandom;
    endtask

    task automatic step();
        bit a[0:1];
        bit g0, g1, e0, e1;
        bit n_ack[0:1];
        bit n_err[0:1];
        @(negedge i_clk);
        a[0] = m0_ack; a[1] = m1_ack;
        for (int i = 0; i < 2; i++) begin
            if (mreq[i] && a[i]) begin
                if (cont || $urandom_range(0, 99) < p_req[i]) new_txn(i);
                else mreq[i] = 1'b0;
            end else if (!mreq[i] && $urandom_range(0, 99) < p_req[i]) begin
                new_txn(i);
            end
        end
        s_rdata = $urandom;
        if (s_req) s_ack = ($urandom_range(0, 99) < ack_pct);
        else       s_ack = ($urandom_range(0, 99) < 15);
        #1;
        chk("s_req",      s_req,      (own >= 0));
        chk("s_we",       s_we,       e_we);
        chk("s_addr",     s_addr,     e_addr);
        chk("s_wdata",    s_wdata,    e_wd);
        chk("m0_ack",     m0_ack,     e_ack[0]);
        chk("m0_err",     m0_err,     e_err[0]);
        chk("m0_rdata",   m0_rdata,   e_rd[0]);
        chk("m1_ack",     m1_ack,     e_ack[1]);
        chk("m1_err",     m1_err,     e_err[1]);
        chk("m1_rdata",   m1_rdata,   e_rd[1]);
        chk("core_stall", core_stall, mreq[0] & ~e_ack[0]);

        if (s_req) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        if (m0_err || m1_err) chk("tmo_len", last_run, TO);
        if (phase_b) begin
            if (m0_ack) since_m1++;
            if (m1_ack) begin
                if (m1_seen > 0) chk("starve_order", since_m1, MW);
                m1_seen++;
                since_m1 = 0;
            end
        end

        g0 = 0; g1 = 0;
        e0 = mreq[0] && !e_ack[0];
        e1 = mreq[1] && !e_ack[1];
        n_ack[0] = 0; n_ack[1] = 0; n_err[0] = 0; n_err[1] = 0;
        if (own < 0) begin
            if (e1 && (starve == MW || !mreq[0])) g1 = 1;
            else if (e0) g0 = 1;
            if (g0 || g1) begin
                own = g1 ? 1 : 0;
                elapsed = 0;
                e_we = mwe[own]; e_addr = maddr[own]; e_wd = mwd[own];
            end
        end else if (s_ack) begin
            n_ack[own] = 1; e_rd[own] = s_rdata; own = -1;
        end else if (elapsed == TO - 1) begin
            n_ack[own] = 1; n_err[own] = 1; e_rd[own] = '0; own = -1;
        end else begin
            elapsed++;
        end
        if (g1) starve = 0;
        else if (g0 && mreq[1]) starve = (starve < MW) ? starve + 1 : MW;
        else if (!mreq[1]) starve = 0;
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = n_ack[i]; e_err[i] = n_err[i];
        end
    endtask

    task automatic cfg(input int p0, input int p1, input bit c, input int ap);
        p_req[0] = p0; p_req[1] = p1; cont = c; ack_pct = ap;
    endtask

    initial begin
        i_rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 0; mwe[i] = 0; maddr[i] = '0; mwd[i] = '0;
        end
        s_ack = 0; s_rdata = '0;
        since_m1 = 0; m1_seen = 0; phase_b = 0;
        model_reset();
        cfg(0, 0, 0, 0);
        repeat (3) @(negedge i_clk);
        chk("rst_s_req",  s_req,  1'b0);
        chk("rst_s_addr", s_addr, '0);
        chk("rst_m0_ack", m0_ack, 1'b0);
        chk("rst_m1_ack", m1_ack, 1'b0);
        chk("rst_m0_rd",  m0_rdata, '0);
        i_rst_n = 1'b1;

        cfg(60, 0, 0, 60);   repeat (200) step();
        cfg(0, 60, 0, 60);   repeat (200) step();
        cfg(100, 100, 1, 50);
        phase_b = 1;         repeat (300) step();
        phase_b = 0;
        cfg(50, 50, 0, 0);   repeat (200) step();

        // Drive M1 into a hung access, then pull reset mid-transaction.
        cfg(0, 100, 0, 0);
        begin
            int budget = 60;
            while (own != 1 && budget > 0) begin step(); budget--; end
            if (own != 1) chk("reach_busy_m1", 0, 1);
        end
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_s_req",  s_req,    1'b0);
        chk("arst_m0_ack", m0_ack,   1'b0);
        chk("arst_m1_ack", m1_ack,   1'b0);
        chk("arst_m1_err", m1_err,   1'b0);
        chk("arst_s_addr", s_addr,   '0);
        chk("arst_m1_rd",  m1_rdata, '0);
        model_reset();
        for (int i = 0; i < 2; i++) mreq[i] = 0;
        cfg(0, 0, 0, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        cfg(40, 40, 0, 70);  repeat (400) step();
        cfg(0, 0, 0, 100);   repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
